aes128_encrypt_core: RTL and testbench
======================================

Name: aes128_encrypt_core

Overview:
- Iterative AES-128 encryption engine (FIPS-197): one 128-bit plaintext block and one 128-bit key in, one 128-bit ciphertext block out.
- Sits behind the credential-storage logic of the parking controller. Entry and exit passwords are encrypted with a fixed system key (ASCII "password12345678") before they are stored or compared.
- Computes one AES round per clock. Round keys are expanded on the fly, so there is no key RAM.

Parameters:
- None. Round count (10) and key size (128) are fixed constants taken from the shared package.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; data_in and key_in are sampled on the same edge
- data_in  input  128  plaintext; byte 0 = bits [127:120]
- key_in  input  128  cipher key; byte 0 = bits [127:120]
- data_out  output  128  ciphertext; valid from the done pulse, held until the next completion
- done  output  1  one-cycle pulse when data_out updates
- busy  output  1  high while an encryption is in progress

Behaviour:
- State mapping:
  - 16-byte state, column-major per FIPS-197.
  - Byte k = bits [127-8k -: 8].
  - State byte (row r, col c) = byte 4c+r.
- Reset (async, rst=1):
  - data_out=0, done=0, busy=0.
  - round counter=0, state register=0, round-key register=0.
  - A reset asserted mid-operation aborts the operation. No done pulse is produced, and data_out reads 0.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, round counter 1..10.
- Start edge (start=1 and busy=0):
  - state <= data_in XOR key_in (initial AddRoundKey).
  - rkey <= key_in.
  - round <= 1; busy <= 1.
- Start while busy=1 is ignored: no queueing, and the current operation is unaffected.
- Each RUN edge, round r:
  - next_rkey = KeyExpand(rkey, Rcon[r]).
  - For r<10: state <= MixColumns(ShiftRows(SubBytes(state))) XOR next_rkey.
  - For r=10: MixColumns is skipped.
  - rkey <= next_rkey; round <= r+1.
- Completion, on the round-10 edge:
  - data_out <= round-10 result; done <= 1; busy <= 0; return to IDLE.
  - done deasserts on the following edge.
- Latency:
  - Start sampled at edge 0; done and data_out are valid after edge 10.
  - Back-to-back throughput: 1 block per 11 cycles. The earliest new start is the cycle in which done=1, because busy is already 0 then.
- KeyExpand(w0..w3, rc):
  - t = SubWord(RotWord(w3)) XOR {rc,00,00,00}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Arithmetic:
  - MixColumns uses GF(2^8) xtime with reduction polynomial 0x11B.
  - Each column is multiplied by the circulant matrix [2 3 1 1].
- All round logic is purely combinational between the state and rkey registers. No combinational path from inputs to outputs.
- Changes to data_in and key_in after the start edge do not affect the result in flight.
- Encryption is deterministic: identical (data_in, key_in) always yields an identical data_out. Password equality comparisons downstream rely on this.

Decomposition:
- Package aes_pkg holds:
  - the AES_ROUNDS=10 constant;
  - the Rcon constant array;
  - the state typedef (16 x 8-bit byte array);
  - functions xtime, mix_column, shift_rows.
- Sub-module aes_sbox: combinational 8-bit S-box (256-entry case/ROM).
  - Instantiated 16 times for SubBytes and 4 times for SubWord.

Test Plan:
- FIPS-197 Appendix B vector:
  - key=2b7e151628aed2a6abf7158809cf4f3c, data_in=3243f6a8885a308d313198a2e0370734, start pulse.
  - Expected: 10 cycles later done=1 and data_out=3925841d02dc09fbdc118597196a0b32; busy high for exactly 10 cycles.
- FIPS-197 Appendix C.1 vector:
  - key=000102030405060708090a0b0c0d0e0f, data_in=00112233445566778899aabbccddeeff.
  - Expected: data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Determinism and back-to-back:
  - Encrypt the same 128-bit password twice with key "password12345678", issuing the second start in the done cycle.
  - Expected: identical data_out; second done exactly 11 cycles after the first. A different password gives a different data_out.
- Start while busy:
  - Pulse start again with different data on cycle 5.
  - Expected: ignored; result equals the first vector's ciphertext; only one done pulse.
- Async reset mid-operation:
  - Assert rst at cycle 4 without waiting for a clock edge.
  - Expected: busy, done and data_out go to 0 immediately; no done pulse follows. After release, a fresh start completes correctly.
- Input hold-off:
  - Change data_in and key_in every cycle after the start edge.
  - Expected: data_out equals the ciphertext of the values sampled at start.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and the pure round helpers used by the
// iterative encryption core.
package aes_pkg;

  localparam int AES_ROUNDS     = 10;
  localparam int AES_KEY_BITS   = 128;
  localparam int AES_BLOCK_BITS = 128;

  // Round constants for rounds 1..10; index 0 is never used.
  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte 0 sits in bits [127:120], so a plain 128-bit vector maps straight in.
  typedef logic [0:15][7:0] aes_state_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column times the circulant [2 3 1 1]; col[31:24] is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = s[4*((c+r)%4)+r];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_encrypt_core_if.sv
// Request/response bundle of the AES-128 core: the requester drives start and
// the operands, the core returns the ciphertext with done/busy status.
interface aes128_encrypt_core_if;
  import aes_pkg::*;

  // start is a one-cycle request, accepted only while busy is low; data_in and
  // key_in are sampled on that edge. done pulses for one cycle when data_out
  // updates, and data_out then holds until the next completion.
  logic                      start;
  logic [AES_BLOCK_BITS-1:0] data_in;
  logic [AES_KEY_BITS-1:0]   key_in;
  logic [AES_BLOCK_BITS-1:0] data_out;
  logic                      done;
  logic                      busy;

  modport master (
    output start, data_in, key_in,
    input  data_out, done, busy
  );

  modport slave (
    input  start, data_in, key_in,
    output data_out, done, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a 256-entry constant ROM.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // Entry 0 occupies the top byte, so entry a starts at bit 8*(255-a)+7.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX_ROM[{~a_i, 3'b111} -: 8];

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption: one round per clock, round keys expanded on
// the fly from the previous round key, 11 cycles per block.
module aes128_encrypt_core
  import aes_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  aes128_encrypt_core_if.slave       bus,
  output aes_fsm_e                   dbg_state_o
);

  aes_fsm_e                  st_q, st_d;
  aes_state_t                state_q, state_d;
  aes_state_t                rkey_q, rkey_d;
  logic [3:0]                round_q, round_d;
  logic [AES_BLOCK_BITS-1:0] data_out_q, data_out_d;
  logic                      done_q, done_d;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_out;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  key_tmp;
  logic [7:0]   rcon_byte;
  logic [127:0] next_rkey;
  logic         last_round;

  // SubBytes over the whole state.
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .a_i (state_q[i]),
      .y_o (sub_bytes[127-8*i -: 8])
    );
  end

  // SubWord(RotWord(w3)) for the key schedule.
  assign rot_word = {rkey_q[13], rkey_q[14], rkey_q[15], rkey_q[12]};

  for (genvar j = 0; j < 4; j++) begin : g_sub_word
    aes_sbox u_sbox (
      .a_i (rot_word[31-8*j -: 8]),
      .y_o (sub_word[31-8*j -: 8])
    );
  end

  assign last_round = (round_q == 4'(AES_ROUNDS));

  always_comb begin
    rcon_byte = 8'h00;
    if (round_q >= 4'd1 && round_q <= 4'(AES_ROUNDS)) begin
      rcon_byte = RCON[round_q];
    end
    key_tmp            = sub_word ^ {rcon_byte, 24'h000000};
    next_rkey[127:96]  = rkey_q[0:3]   ^ key_tmp;
    next_rkey[95:64]   = rkey_q[4:7]   ^ next_rkey[127:96];
    next_rkey[63:32]   = rkey_q[8:11]  ^ next_rkey[95:64];
    next_rkey[31:0]    = rkey_q[12:15] ^ next_rkey[63:32];
  end

  always_comb begin
    shifted = shift_rows(sub_bytes);
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
    // The final round leaves out MixColumns.
    round_out = (last_round ? shifted : mixed) ^ next_rkey;
  end

  always_comb begin
    st_d       = st_q;
    state_d    = state_q;
    rkey_d     = rkey_q;
    round_d    = round_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = bus.data_in ^ bus.key_in;
          rkey_d  = bus.key_in;
          round_d = 4'd1;
          st_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        rkey_d  = next_rkey;
        round_d = round_q + 4'd1;
        if (last_round) begin
          data_out_d = round_out;
          done_d     = 1'b1;
          round_d    = 4'd0;
          st_d       = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      state_q    <= '0;
      rkey_q     <= '0;
      round_q    <= 4'd0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      state_q    <= state_d;
      rkey_q     <= rkey_d;
      round_q    <= round_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;
  assign bus.busy     = (st_q == ST_RUN);
  assign dbg_state_o  = st_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed bench for aes128_encrypt_core: FIPS-197 vectors, back-to-back,
// ignored starts, async abort, operand hold-off and random blocks.
module tb_aes128_encrypt_core;
  import aes_pkg::*;

  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_SYS = "password12345678";
  localparam logic [127:0] PW1   = "entry_pw_1234567";
  localparam logic [127:0] PW2   = "exit_pw_76543210";

  logic     clk;
  logic     rst;
  aes_fsm_e dbg_state;

  aes128_encrypt_core_if bus ();

  aes128_encrypt_core dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [127:0] exp_q[$];
  logic [127:0] sb_exp;

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne128(input string tag, input logic [127:0] obs, input logic [127:0] other);
    total++;
    assert (obs !== other) else begin
      bad++;
      $error("FAIL %s observed=%h expected_not=%h", tag, obs, other);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_done observed=%h expected=none", bus.data_out);
      end
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        chk128("sb_data_out", bus.data_out, sb_exp);
      end
    end
  end

  // ---------------- independent reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv, t;
    inv = 8'h01;
    t = x;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      inv = gmul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s[16];
    logic [7:0] k[16];
    logic [7:0] t[16];
    logic [7:0] w[4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      w[0] = sbox_m(k[13]) ^ rc;
      w[1] = sbox_m(k[14]);
      w[2] = sbox_m(k[15]);
      w[3] = sbox_m(k[12]);
      for (int i = 0; i < 4; i++) k[i] = k[i] ^ w[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbox_m(s[i]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {32'($urandom_range(32'hffff_ffff, 0)), 32'($urandom_range(32'hffff_ffff, 0)),
            32'($urandom_range(32'hffff_ffff, 0)), 32'($urandom_range(32'hffff_ffff, 0))};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where done is seen (n=11 on time).
  task automatic run_block(input logic [127:0] d, input logic [127:0] k, input logic [127:0] exp,
                           input bit scramble, output int n, output int busy_cnt);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.key_in  = k;
    exp_q.push_back(exp);
    n = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (scramble) begin
        bus.data_in = rand128();
        bus.key_in  = rand128();
      end
      if (bus.busy) busy_cnt++;
    end while (!bus.done && n < 40);
  endtask

  // ---------------- directed sequence ----------------
  int n, bc, d0;
  logic [127:0] rd, rk, ref_pw1;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_in = '0;
    bus.key_in = '0;
    repeat (3) @(negedge clk);
    chk_int("rst_busy", int'(bus.busy), 0);
    chk_int("rst_done", int'(bus.done), 0);
    chk128("rst_data_out", bus.data_out, 128'h0);
    chk_int("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 Appendix B
    run_block(PT_B, K_B, CT_B, 1'b0, n, bc);
    chk_int("fips_b_latency", n, 11);
    chk_int("fips_b_busy_cycles", bc, 10);
    chk128("fips_b_data_out", bus.data_out, CT_B);
    @(negedge clk);
    chk_int("fips_b_done_one_cycle", int'(bus.done), 0);
    chk128("fips_b_data_held", bus.data_out, CT_B);

    // FIPS-197 Appendix C.1
    run_block(PT_C, K_C, CT_C, 1'b0, n, bc);
    chk_int("fips_c_latency", n, 11);
    chk128("fips_c_data_out", bus.data_out, CT_C);

    // Determinism and back-to-back starts in the done cycle
    @(negedge clk);
    ref_pw1 = aes_model(PW1, K_SYS);
    run_block(PW1, K_SYS, ref_pw1, 1'b0, n, bc);
    chk128("pw1_first", bus.data_out, ref_pw1);
    run_block(PW1, K_SYS, ref_pw1, 1'b0, n, bc);
    chk_int("b2b_done_spacing", n, 11);
    chk128("pw1_second", bus.data_out, ref_pw1);
    run_block(PW2, K_SYS, aes_model(PW2, K_SYS), 1'b0, n, bc);
    chk_int("b2b_third_spacing", n, 11);
    chk_ne128("pw2_differs", bus.data_out, ref_pw1);

    // Start while busy is ignored
    @(posedge clk); #1 d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = PT_B; bus.key_in = K_B;
    exp_q.push_back(CT_B);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    repeat (3) begin @(negedge clk); n++; end
    bus.start = 1'b1; bus.data_in = PT_C; bus.key_in = K_C;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    chk_int("busy_mid_run", int'(bus.busy), 1);
    while (!bus.done && n < 40) begin @(negedge clk); n++; end
    chk_int("ignored_start_latency", n, 11);
    chk128("ignored_start_data", bus.data_out, CT_B);
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    chk_int("ignored_start_one_done", done_cnt - d0, 1);

    // Asynchronous reset mid-operation
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.data_in = PT_C; bus.key_in = K_C;
    exp_q.push_back(CT_C);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk_int("abort_busy", int'(bus.busy), 0);
    chk_int("abort_done", int'(bus.done), 0);
    chk128("abort_data_out", bus.data_out, 128'h0);
    chk_int("abort_state", int'(dbg_state), int'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    chk_int("abort_no_done", done_cnt - d0, 0);
    @(negedge clk);
    run_block(PT_C, K_C, CT_C, 1'b0, n, bc);
    chk_int("after_abort_latency", n, 11);
    chk128("after_abort_data", bus.data_out, CT_C);

    // Operand hold-off: inputs scrambled every cycle after the start edge
    @(negedge clk);
    rd = rand128();
    rk = rand128();
    run_block(rd, rk, aes_model(rd, rk), 1'b1, n, bc);
    chk_int("holdoff_latency", n, 11);
    chk128("holdoff_data", bus.data_out, aes_model(rd, rk));

    // Random blocks, back-to-back
    for (int i = 0; i < 3; i++) begin
      rd = rand128();
      rk = rand128();
      run_block(rd, rk, aes_model(rd, rk), 1'b0, n, bc);
      chk_int("rand_latency", n, 11);
    end

    repeat (3) @(negedge clk);
    chk_int("sb_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
